// File: rtl/dma_arbiter.sv
// dma_arbiter: shares one DRAM command port among the image-fetch, weight-fetch and
// result-writeback units. Grants rotate round-robin, one single-beat command per cycle.
// An in-order tag FIFO remembers who issued each outstanding read, so that return data
// is steered back to that requester.
module dma_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_img_rd_req,
  input  logic [ADDR_W-1:0] i_img_rd_addr,
  output logic              o_img_rd_gnt,
  output logic              o_img_rd_valid,
  output logic [DATA_W-1:0] o_img_rd_data,
  input  logic              i_wgt_rd_req,
  input  logic [ADDR_W-1:0] i_wgt_rd_addr,
  output logic              o_wgt_rd_gnt,
  output logic              o_wgt_rd_valid,
  output logic [DATA_W-1:0] o_wgt_rd_data,
  input  logic              i_res_wr_req,
  input  logic [ADDR_W-1:0] i_res_wr_addr,
  input  logic [DATA_W-1:0] i_res_wr_data,
  output logic              o_res_wr_gnt,
  output logic              o_dma_rd_en,
  output logic [ADDR_W-1:0] o_dma_rd_addr,
  input  logic [DATA_W-1:0] i_dma_rd_data,
  input  logic              i_dma_rd_ready,
  output logic              o_dma_wr_en,
  output logic [ADDR_W-1:0] o_dma_wr_addr,
  output logic [DATA_W-1:0] o_dma_wr_data,
  output logic              o_busy,
  output logic              o_err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SRC_IMG = 2'd0,
    SRC_WGT = 2'd1,
    SRC_WR  = 2'd2
  } src_e;

  src_e               r_last;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [TAG_DEPTH-1:0] r_tags;     // 0 = img, 1 = wgt
  logic               r_dma_rd_en;
  logic [ADDR_W-1:0]  r_dma_rd_addr;
  logic               r_dma_wr_en;
  logic [ADDR_W-1:0]  r_dma_wr_addr;
  logic [DATA_W-1:0]  r_dma_wr_data;
  logic               r_img_rd_valid;
  logic [DATA_W-1:0]  r_img_rd_data;
  logic               r_wgt_rd_valid;
  logic [DATA_W-1:0]  r_wgt_rd_data;
  logic               r_err;

  logic w_rd_full;
  logic w_img_elig;
  logic w_wgt_elig;
  logic w_wr_elig;
  logic w_img_gnt;
  logic w_wgt_gnt;
  logic w_wr_gnt;
  logic w_push;
  logic w_pop;
  logic w_head_tag;

  // Full is judged on the registered count, so a pop in the same cycle does not unblock reads.
  assign w_rd_full  = (r_count == CNT_W'(TAG_DEPTH));
  assign w_img_elig = i_img_rd_req && !w_rd_full;
  assign w_wgt_elig = i_wgt_rd_req && !w_rd_full;
  assign w_wr_elig  = i_res_wr_req;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_img_gnt = 1'b0;
    w_wgt_gnt = 1'b0;
    w_wr_gnt  = 1'b0;
    if (i_rst) begin
      case (r_last)
        SRC_IMG: begin
          if      (w_wgt_elig) w_wgt_gnt = 1'b1;
          else if (w_wr_elig)  w_wr_gnt  = 1'b1;
          else if (w_img_elig) w_img_gnt = 1'b1;
        end
        SRC_WGT: begin
          if      (w_wr_elig)  w_wr_gnt  = 1'b1;
          else if (w_img_elig) w_img_gnt = 1'b1;
          else if (w_wgt_elig) w_wgt_gnt = 1'b1;
        end
        default: begin
          if      (w_img_elig) w_img_gnt = 1'b1;
          else if (w_wgt_elig) w_wgt_gnt = 1'b1;
          else if (w_wr_elig)  w_wr_gnt  = 1'b1;
        end
      endcase
    end
  end

  assign w_push     = w_img_gnt || w_wgt_gnt;
  assign w_pop      = i_dma_rd_ready && (r_count != '0);
  assign w_head_tag = r_tags[r_rd_ptr];

  // Arbitration pointer, tag FIFO and outstanding-read count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_last   <= SRC_WR;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      // NOTE: the tag store is only TAG_DEPTH bits, so it is cleared with the rest of the state.
      r_tags   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same clock edge.
      if (w_img_gnt)      r_last <= SRC_IMG;
      else if (w_wgt_gnt) r_last <= SRC_WGT;
      else if (w_wr_gnt)  r_last <= SRC_WR;
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_wgt_gnt;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // DRAM command register: one-cycle enable pulse, buses hold their last value.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_dma_rd_en   <= 1'b0;
      r_dma_rd_addr <= '0;
      r_dma_wr_en   <= 1'b0;
      r_dma_wr_addr <= '0;
      r_dma_wr_data <= '0;
    end else begin
      r_dma_rd_en <= w_push;
      r_dma_wr_en <= w_wr_gnt;
      if (w_img_gnt) r_dma_rd_addr <= i_img_rd_addr;
      if (w_wgt_gnt) r_dma_rd_addr <= i_wgt_rd_addr;
      if (w_wr_gnt) begin
        r_dma_wr_addr <= i_res_wr_addr;
        r_dma_wr_data <= i_res_wr_data;
      end
    end
  end

  // Return steering by head tag, plus the sticky orphan-return flag.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_img_rd_valid <= 1'b0;
      r_img_rd_data  <= '0;
      r_wgt_rd_valid <= 1'b0;
      r_wgt_rd_data  <= '0;
      r_err          <= 1'b0;
    end else begin
      r_img_rd_valid <= w_pop && !w_head_tag;
      r_wgt_rd_valid <= w_pop &&  w_head_tag;
      if (w_pop && !w_head_tag) r_img_rd_data <= i_dma_rd_data;
      if (w_pop &&  w_head_tag) r_wgt_rd_data <= i_dma_rd_data;
      if (i_dma_rd_ready && (r_count == '0)) r_err <= 1'b1;
    end
  end

  assign o_img_rd_gnt   = w_img_gnt;
  assign o_wgt_rd_gnt   = w_wgt_gnt;
  assign o_res_wr_gnt   = w_wr_gnt;
  assign o_img_rd_valid = r_img_rd_valid;
  assign o_img_rd_data  = r_img_rd_data;
  assign o_wgt_rd_valid = r_wgt_rd_valid;
  assign o_wgt_rd_data  = r_wgt_rd_data;
  assign o_dma_rd_en    = r_dma_rd_en;
  assign o_dma_rd_addr  = r_dma_rd_addr;
  assign o_dma_wr_en    = r_dma_wr_en;
  assign o_dma_wr_addr  = r_dma_wr_addr;
  assign o_dma_wr_data  = r_dma_wr_data;
  assign o_busy         = (r_count != '0) || r_dma_rd_en || r_dma_wr_en;
  assign o_err          = r_err;

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed literal checks followed by randomized traffic, all outputs
// compared every cycle against a queue-based behavioural model of the arbiter.
module tb_dma_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          img_req, wgt_req, wr_req;
  logic [AW-1:0] img_addr, wgt_addr, wr_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_ready;
  logic          img_gnt, wgt_gnt, wr_gnt;
  logic          img_valid, wgt_valid;
  logic [DW-1:0] img_data, wgt_data;
  logic          dma_rd_en, dma_wr_en;
  logic [AW-1:0] dma_rd_addr, dma_wr_addr;
  logic [DW-1:0] dma_wr_data;
  logic          busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_img_rd_req(img_req), .i_img_rd_addr(img_addr), .o_img_rd_gnt(img_gnt),
    .o_img_rd_valid(img_valid), .o_img_rd_data(img_data),
    .i_wgt_rd_req(wgt_req), .i_wgt_rd_addr(wgt_addr), .o_wgt_rd_gnt(wgt_gnt),
    .o_wgt_rd_valid(wgt_valid), .o_wgt_rd_data(wgt_data),
    .i_res_wr_req(wr_req), .i_res_wr_addr(wr_addr), .i_res_wr_data(wr_data),
    .o_res_wr_gnt(wr_gnt),
    .o_dma_rd_en(dma_rd_en), .o_dma_rd_addr(dma_rd_addr),
    .i_dma_rd_data(rd_data), .i_dma_rd_ready(rd_ready),
    .o_dma_wr_en(dma_wr_en), .o_dma_wr_addr(dma_wr_addr), .o_dma_wr_data(dma_wr_data),
    .o_busy(busy), .o_err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outstanding reads are a queue of requester ids (0=img, 1=wgt); last is 0/1/2 = img/wgt/wr.
  int            m_q[$];
  int            m_last;
  logic          m_rd_en, m_wr_en, m_img_v, m_wgt_v, m_err;
  logic [AW-1:0] m_rd_addr, m_wr_addr;
  logic [DW-1:0] m_wr_data, m_img_d, m_wgt_d;

  task automatic model_reset();
    m_q.delete();
    m_last = 2;
    m_rd_en = 0; m_wr_en = 0; m_img_v = 0; m_wgt_v = 0; m_err = 0;
    m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0; m_img_d = '0; m_wgt_d = '0;
  endtask

  initial model_reset();

  // Compare process: outputs are stable at the falling edge; model then steps one cycle.
  always @(negedge clk) begin
    bit elig[3];
    int g;
    int s;
    int tag;
    if (!rst) model_reset();
    check("dma_rd_en",   dma_rd_en,   m_rd_en);
    check("dma_rd_addr", dma_rd_addr, m_rd_addr);
    check("dma_wr_en",   dma_wr_en,   m_wr_en);
    check("dma_wr_addr", dma_wr_addr, m_wr_addr);
    check("dma_wr_data", dma_wr_data, m_wr_data);
    check("img_valid",   img_valid,   m_img_v);
    check("img_data",    img_data,    m_img_d);
    check("wgt_valid",   wgt_valid,   m_wgt_v);
    check("wgt_data",    wgt_data,    m_wgt_d);
    check("err",         err,         m_err);
    check("busy",        busy,        (m_q.size() != 0) || m_rd_en || m_wr_en);
    g = -1;
    elig[0] = img_req && (m_q.size() < DEPTH);
    elig[1] = wgt_req && (m_q.size() < DEPTH);
    elig[2] = wr_req;
    if (rst) begin
      for (int i = 1; i <= 3; i++) begin
        s = (m_last + i) % 3;
        if (g < 0 && elig[s]) g = s;
      end
    end
    check("img_gnt", img_gnt, g == 0);
    check("wgt_gnt", wgt_gnt, g == 1);
    check("wr_gnt",  wr_gnt,  g == 2);
    if (rst) begin
      if (g >= 0) m_last = g;
      m_rd_en = (g == 0) || (g == 1);
      m_wr_en = (g == 2);
      if (g == 0) m_rd_addr = img_addr;
      if (g == 1) m_rd_addr = wgt_addr;
      if (g == 2) begin m_wr_addr = wr_addr; m_wr_data = wr_data; end
      m_img_v = 0; m_wgt_v = 0;
      if (rd_ready) begin
        if (m_q.size() == 0) m_err = 1;
        else begin
          tag = m_q.pop_front();
          if (tag == 0) begin m_img_v = 1; m_img_d = rd_data; end
          else          begin m_wgt_v = 1; m_wgt_d = rd_data; end
        end
      end
      if (g == 0 || g == 1) m_q.push_back(g);
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_seq [8];
    exp_seq = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001};
    rst = 0;
    img_req = 1; wgt_req = 1; wr_req = 1;
    img_addr = 0; wgt_addr = 2040; wr_addr = 32'h100; wr_data = 32'hdead;
    rd_data = 0; rd_ready = 0;
    #1;
    // Reset held with requests active: no grants, nothing busy.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lit_rst_gnt", {img_gnt, wgt_gnt, wr_gnt}, 3'b000);
      check("lit_rst_busy", busy, 1'b0);
      check("lit_rst_rd_en", dma_rd_en, 1'b0);
      next_cycle();
    end
    rst = 1;
    // All three requesting: img,wgt,wr,img,wgt,wr, then reads full so only wr.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("lit_rr_seq", {img_gnt, wgt_gnt, wr_gnt}, exp_seq[k]);
      if (k == 1) begin
        check("lit_rd_en_after_img", dma_rd_en, 1'b1);
        check("lit_rd_addr_img", dma_rd_addr, 32'd0);
      end
      if (k == 2) check("lit_rd_addr_wgt", dma_rd_addr, 32'd2040);
      if (k >= 1) check("lit_busy", busy, 1'b1);
      next_cycle();
    end
    // One return: pop this cycle still sees full, img granted the cycle after.
    rd_ready = 1; rd_data = 32'h1234;
    @(negedge clk);
    check("lit_full_pop_gnt", {img_gnt, wgt_gnt, wr_gnt}, 3'b001);
    next_cycle();
    rd_ready = 0;
    @(negedge clk);
    check("lit_gnt_after_pop", {img_gnt, wgt_gnt, wr_gnt}, 3'b100);
    check("lit_img_valid", img_valid, 1'b1);
    check("lit_img_data", img_data, 32'h1234);
    check("lit_wgt_valid", wgt_valid, 1'b0);
    next_cycle();
    // Reset with reads outstanding, then an orphan return.
    img_req = 0; wgt_req = 0; wr_req = 0;
    rst = 0;
    next_cycle();
    rst = 1;
    @(negedge clk);
    check("lit_busy_after_rst", busy, 1'b0);
    next_cycle();
    next_cycle();
    rd_ready = 1;
    next_cycle();
    rd_ready = 0;
    @(negedge clk);
    check("lit_orphan_err", err, 1'b1);
    check("lit_orphan_valid", {img_valid, wgt_valid}, 2'b00);
    next_cycle();
    @(negedge clk);
    check("lit_err_sticky", err, 1'b1);
    next_cycle();
    // Randomized traffic checked by the model every cycle.
    for (int k = 0; k < 4000; k++) begin
      rst      = ($urandom_range(0, 299) != 0);
      img_req  = ($urandom_range(0, 2) != 0);
      wgt_req  = ($urandom_range(0, 2) != 0);
      wr_req   = ($urandom_range(0, 2) == 0);
      img_addr = $urandom();
      wgt_addr = $urandom();
      wr_addr  = $urandom();
      wr_data  = $urandom();
      rd_data  = $urandom();
      rd_ready = ($urandom_range(0, 2) == 0);
      next_cycle();
    end
    rd_ready = 0; img_req = 0; wgt_req = 0; wr_req = 0;
    next_cycle();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
